inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Instruction fetch front end. Issues line-sized burst reads on the Sysbus, splits each
//  response beat into 32-bit instructions and buffers them, with PCs, in a FIFO for decode.
//  Supports redirect (flush and refetch) and halts on an all-zero instruction word.
//  Sits between top-level bus ports and the decode stage.
// PARAMETERS
//  BUS_DATA_WIDTH  64  response beat width; multiple of 32; INSTS_PER_BEAT = BUS_DATA_WIDTH/32
//  BUS_TAG_WIDTH   13  Sysbus tag width
//  BURST_BEATS     8   beats per request; LINE_BYTES = BURST_BEATS*BUS_DATA_WIDTH/8
//  QUEUE_DEPTH     32  instruction FIFO entries; power of 2; >= BURST_BEATS*INSTS_PER_BEAT
// PORTS
//  clk             in   1               clock
//  reset           in   1               reset, synchronous, active-high
//  entry           in   64              PC loaded at reset
//  redirect_valid  in   1               one-cycle pulse: flush and refetch from redirect_pc
//  redirect_pc     in   64              redirect target; 4-byte aligned
//  bus_reqcyc      out  1               request valid
//  bus_req         out  BUS_DATA_WIDTH  request address (line-aligned)
//  bus_reqtag      out  BUS_TAG_WIDTH   `SYSBUS_READ<<12 | `SYSBUS_MEMORY<<8, constant
//  bus_reqack      in   1               request accepted
//  bus_respcyc     in   1               response beat valid
//  bus_respack     out  1               response beat consumed
//  bus_resp        in   BUS_DATA_WIDTH  response data
//  bus_resptag     in   BUS_TAG_WIDTH   ignored; one request outstanding at a time
//  inst_valid      out  1               FIFO head valid (= !empty)
//  inst            out  32              head instruction
//  inst_pc         out  64              head instruction PC
//  inst_ready      in   1               pop head when inst_valid && inst_ready
//  halted          out  1               zero word seen, FIFO drained, no fetch active
// BEHAVIOUR
//  - Reset: fetch_pc <= entry; state IDLE; FIFO empty.
//  - Reset values: bus_reqcyc=0, bus_req=0, bus_respack=0, inst_valid=0, halted=0.
//  - Reset mid-burst abandons the burst. No drain.
//  - States: IDLE, REQ, RESP, DRAIN, HALT.
//  - IDLE -> REQ: when free FIFO slots >= BURST_BEATS*INSTS_PER_BEAT and redirect_valid=0.
//  - REQ: bus_reqcyc=1; bus_req = fetch_pc & ~(LINE_BYTES-1).
//    - Address and tag stay stable until bus_reqack=1 is sampled.
//    - On ack: next state RESP; bus_reqcyc=0 from the next cycle.
//  - RESP/DRAIN beat handling:
//    - bus_respack = bus_respcyc (combinational) in RESP and DRAIN, else 0.
//    - Each acked beat increments beat_cnt.
//    - Beat BURST_BEATS-1: beat_cnt <= 0 and the state exits.
//  - RESP word handling:
//    - Word k = bus_resp[32k+31:32k], PC = line_base + beat_cnt*BUS_DATA_WIDTH/8 + 4k.
//    - Word k is enqueued in ascending k order.
//    - Words with PC < fetch_pc are dropped (mid-line entry or redirect).
//  - Line advance: fetch_pc <= line_base + LINE_BYTES at burst end. PC arithmetic wraps mod 2^64.
//  - Zero word:
//    - The first all-zero word in RESP is not enqueued.
//    - It and all later words of the burst are dropped.
//    - The remaining beats are still acked, then HALT.
//  - RESP normal exit: last beat -> IDLE (or HALT if a zero word was seen).
//  - HALT: no requests. halted=1 while in HALT and FIFO empty.
//  - Redirect (any state, highest priority):
//    - FIFO flushed that cycle; pop and enqueue in that cycle are suppressed.
//    - inst_valid=0 next cycle; fetch_pc <= redirect_pc.
//    - IDLE or HALT -> IDLE.
//    - REQ: finish the handshake, then DRAIN the full burst.
//    - RESP -> DRAIN; a beat in the redirect cycle is acked and discarded.
//    - On the last beat -> IDLE.
//  - DRAIN: ack and discard beats; last beat -> IDLE.
//  - FIFO: up to INSTS_PER_BEAT pushes plus 1 pop per cycle.
//    - The space check before REQ guarantees no overflow; overflow is a bench assertion.
//    - Pop of an empty FIFO is ignored.
// TESTING
//  1. reset, entry=0x1000, nonzero memory, inst_ready=1:
//     -> bus_req=0x1000, reqtag constant; 16 insts with inst_pc 0x1000..0x103C in order;
//        next bus_req=0x1040.
//  2. inst_ready=0, QUEUE_DEPTH=32:
//     -> exactly 2 bursts, no 3rd request; 3rd request only after 16 pops.
//  3. entry=0x1008 -> bus_req=0x1000; first inst_pc=0x1008; 14 insts from that burst.
//  4. redirect_valid, redirect_pc=0x2000 during beat 3:
//     -> beats 3..7 acked, none enqueued; inst_valid=0 next cycle; next bus_req=0x2000.
//  5. word at 0x1014 = 0:
//     -> insts 0x1000..0x1010 only; all 8 beats acked; halted=1 after drain; no request;
//        redirect to 0x1000 resumes fetch.
//  6. bus_reqack delayed 5 cycles plus redirect during REQ:
//     -> bus_req held stable; full burst drained; then bus_req = redirect line.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Sysbus request/response bundle between the fetch front end (master) and memory (slave).
interface inst_fetch_queue_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      reqcyc;
    logic [BUS_DATA_WIDTH-1:0] req;
    logic [BUS_TAG_WIDTH-1:0]  reqtag;
    logic                      reqack;
    logic                      respcyc;
    logic                      respack;
    logic [BUS_DATA_WIDTH-1:0] resp;
    logic [BUS_TAG_WIDTH-1:0]  resptag;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues line bursts on the Sysbus, splits each beat into
// 32-bit instructions and queues them with their PCs for decode. Handles redirects
// (flush + refetch) and halts after an all-zero instruction word.
module inst_fetch_queue #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BURST_BEATS    = 8,
    parameter int QUEUE_DEPTH    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         entry,
    input  logic                redirect_valid,
    input  logic [63:0]         redirect_pc,
    inst_fetch_queue_if.master  bus,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output logic [63:0]         inst_pc,
    input  logic                inst_ready,
    output logic                halted
);

    localparam int IPB             = BUS_DATA_WIDTH / 32;
    localparam int BEAT_BYTES      = BUS_DATA_WIDTH / 8;
    localparam int LINE_BYTES      = BURST_BEATS * BEAT_BYTES;
    localparam int INSTS_PER_BURST = BURST_BEATS * IPB;
    localparam int PTR_W           = $clog2(QUEUE_DEPTH);
    localparam int CNT_W           = PTR_W + 1;
    localparam int BEAT_W          = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

    localparam int SYSBUS_READ   = 1;
    localparam int SYSBUS_MEMORY = 1;
    localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG =
        BUS_TAG_WIDTH'((SYSBUS_READ << 12) | (SYSBUS_MEMORY << 8));
    localparam logic [63:0] LINE_MASK = ~(64'(LINE_BYTES) - 64'd1);

    typedef enum logic [2:0] {IDLE, REQ, RESP, DRAIN, HALT} state_t;

    state_t             state;
    state_t             state_next;

    logic [63:0]        fetch_pc;
    logic [63:0]        req_addr;
    logic [BEAT_W-1:0]  beat_cnt;
    logic               zero_seen;
    logic               drain_pending;

    logic [31:0]        fifo_inst [QUEUE_DEPTH];
    logic [63:0]        fifo_pc   [QUEUE_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   fifo_count;

    logic               space_ok;
    logic               beat_fire;
    logic               last_beat;
    logic               word_phase;
    logic               pop;
    logic [63:0]        beat_base;

    logic [31:0]        beat_word [IPB];
    logic [63:0]        beat_pc   [IPB];
    logic [IPB-1:0]     push_en;
    logic [PTR_W-1:0]   push_slot [IPB];
    logic [CNT_W-1:0]   push_n;
    logic               stop_scan;
    logic               zero_hit;

    logic               unused_resptag;

    assign unused_resptag = ^bus.resptag;

    assign space_ok   = (fifo_count <= CNT_W'(QUEUE_DEPTH - INSTS_PER_BURST));
    assign beat_fire  = ((state == RESP) || (state == DRAIN)) && bus.respcyc;
    assign last_beat  = beat_fire && (beat_cnt == BEAT_W'(BURST_BEATS - 1));
    assign word_phase = (state == RESP) && bus.respcyc && !redirect_valid;
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign beat_base  = req_addr + (64'(beat_cnt) * 64'(BEAT_BYTES));

    assign inst_valid = (fifo_count != '0);
    assign inst       = fifo_inst[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect overrides the normal flow in every state.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            case (state)
                IDLE, HALT: state_next = IDLE;
                REQ:        state_next = bus.reqack ? DRAIN : REQ;
                RESP:       state_next = last_beat ? IDLE : DRAIN;
                DRAIN:      state_next = last_beat ? IDLE : DRAIN;
                default:    state_next = IDLE;
            endcase
        end else begin
            case (state)
                IDLE:    state_next = space_ok ? REQ : IDLE;
                REQ:     if (bus.reqack) state_next = drain_pending ? DRAIN : RESP;
                RESP:    if (last_beat) state_next = (zero_seen || zero_hit) ? HALT : IDLE;
                DRAIN:   if (last_beat) state_next = IDLE;
                HALT:    state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    // Bus-facing outputs and the halted flag.
    always_comb begin
        bus.reqcyc  = (state == REQ);
        bus.req     = (state == REQ) ? BUS_DATA_WIDTH'(req_addr) : '0;
        bus.reqtag  = REQ_TAG;
        bus.respack = beat_fire;
        halted      = (state == HALT) && (fifo_count == '0);
    end

    // Split the current beat into words and compute each word's PC.
    always_comb begin
        for (int k = 0; k < IPB; k++) begin
            beat_word[k] = bus.resp[32*k +: 32];
            beat_pc[k]   = beat_base + 64'(4 * k);
        end
    end

    // Pick the words to enqueue in ascending order, stopping at the first zero word.
    always_comb begin
        stop_scan = zero_seen;
        zero_hit  = 1'b0;
        push_n    = '0;
        push_en   = '0;
        for (int k = 0; k < IPB; k++) begin
            push_slot[k] = wr_ptr + push_n[PTR_W-1:0];
            if (word_phase && !stop_scan && (beat_pc[k] >= fetch_pc)) begin
                if (beat_word[k] == 32'd0) begin
                    stop_scan = 1'b1;
                    zero_hit  = 1'b1;
                end else begin
                    push_en[k] = 1'b1;
                    push_n     = push_n + CNT_W'(1);
                end
            end
        end
    end

    // Fetch bookkeeping: PC, latched request line, beat counter, zero/drain flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc      <= entry;
            req_addr      <= '0;
            beat_cnt      <= '0;
            zero_seen     <= 1'b0;
            drain_pending <= 1'b0;
        end else begin
            if ((state == IDLE) && (state_next == REQ)) begin
                req_addr      <= fetch_pc & LINE_MASK;
                drain_pending <= 1'b0;
                zero_seen     <= 1'b0;
            end else if (word_phase) begin
                zero_seen <= zero_seen | zero_hit;
            end
            if (redirect_valid && (state == REQ)) begin
                drain_pending <= 1'b1;
            end
            if (beat_fire) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if ((state == RESP) && last_beat) begin
                fetch_pc <= req_addr + 64'(LINE_BYTES);
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            wr_ptr     <= wr_ptr + push_n[PTR_W-1:0];
            rd_ptr     <= rd_ptr + PTR_W'(pop);
            fifo_count <= fifo_count + push_n - CNT_W'(pop);
        end
    end

    // FIFO storage writes for the selected words of this beat.
    always_ff @(posedge clk) begin
        for (int k = 0; k < IPB; k++) begin
            if (push_en[k]) begin
                fifo_inst[push_slot[k]] <= beat_word[k];
                fifo_pc[push_slot[k]]   <= beat_pc[k];
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a Sysbus memory model, a pop monitor and
// six scenarios covering fetch order, back-pressure, mid-line entry, redirect and halt.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        halted;

    inst_fetch_queue_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) bus ();

    inst_fetch_queue #(
        .BUS_DATA_WIDTH(64),
        .BUS_TAG_WIDTH (13),
        .BURST_BEATS   (8),
        .QUEUE_DEPTH   (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .entry         (entry),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .bus           (bus),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] req_log [$];
    int          acked_log [$];
    logic [63:0] pop_pc [$];
    int          ack_delay       = 1;
    int          redir_req_cycle = -1;
    int          redir_beat      = -1;
    logic [63:0] redir_target    = 64'd0;
    logic        zero_en         = 1'b0;
    logic [63:0] zero_addr       = 64'd0;
    logic        overflow_seen   = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [63:0] a);
        if (zero_en && (a == zero_addr)) return 32'd0;
        return 32'h5A00_0000 ^ a[31:0];
    endfunction

    function automatic logic [63:0] beatData(input logic [63:0] line, input int b);
        return {memWord(line + 64'(b * 8) + 64'd4), memWord(line + 64'(b * 8))};
    endfunction

    // Memory side of one request: optional ack delay, then eight beats.
    task automatic serveRequest();
        logic [63:0] addr;
        int          acked;
        int          tries;
        bit          stable;
        bit          redir_now;
        addr = bus.req;
        req_log.push_back(addr);
        checkOutput("reqtag", 64'(bus.reqtag), 64'h1100);
        stable = 1'b1;
        for (int d = 0; d < ack_delay; d++) begin
            if (d == redir_req_cycle) begin
                redirect_pc    = redir_target;
                redirect_valid = 1'b1;
            end
            @(negedge clk); #1;
            if (d == redir_req_cycle) begin
                redirect_valid  = 1'b0;
                redir_req_cycle = -1;
            end
            if (reset) return;
            if (bus.reqcyc !== 1'b1 || bus.req !== addr) stable = 1'b0;
        end
        checkOutput("req_stable", 64'(stable), 64'd1);
        bus.reqack = 1'b1;
        @(negedge clk); #1;
        bus.reqack = 1'b0;
        if (reset) return;
        acked = 0;
        for (int b = 0; b < 8; b++) begin
            redir_now   = (b == redir_beat);
            bus.respcyc = 1'b1;
            bus.resp    = beatData(addr, b);
            if (redir_now) begin
                redirect_pc    = redir_target;
                redirect_valid = 1'b1;
            end
            tries = 0;
            #1;
            while (bus.respack !== 1'b1 && tries < 100) begin
                @(negedge clk); #2;
                tries++;
                if (reset) begin
                    bus.respcyc = 1'b0;
                    return;
                end
            end
            if (tries >= 100) begin
                checkOutput("beat_ack_timeout", 64'd0, 64'd1);
                bus.respcyc = 1'b0;
                return;
            end
            acked++;
            @(negedge clk); #1;
            if (redir_now) begin
                redirect_valid = 1'b0;
                redir_beat     = -1;
                checkOutput("flush_valid", 64'(inst_valid), 64'd0);
            end
            if (reset) begin
                bus.respcyc = 1'b0;
                return;
            end
        end
        bus.respcyc = 1'b0;
        acked_log.push_back(acked);
    endtask

    // Memory model: serve each request the DUT raises.
    initial begin
        bus.reqack  = 1'b0;
        bus.respcyc = 1'b0;
        bus.resp    = '0;
        bus.resptag = '0;
        forever begin
            @(negedge clk); #1;
            if (!reset && bus.reqcyc === 1'b1) serveRequest();
        end
    end

    // Pop monitor: log every popped PC and check the word against memory.
    initial begin
        forever begin
            @(negedge clk); #3;
            if (!reset && inst_valid && inst_ready && !redirect_valid) begin
                pop_pc.push_back(inst_pc);
                checkOutput("inst_word", 64'(inst), 64'(memWord(inst_pc)));
            end
            if (dut.fifo_count > 6'd32) overflow_seen = 1'b1;
        end
    end

    task automatic applyStimulus(input logic [63:0] entry_pc, input logic ready);
        ack_delay       = 1;
        redir_req_cycle = -1;
        redir_beat      = -1;
        zero_en         = 1'b0;
        reset           = 1'b1;
        entry           = entry_pc;
        inst_ready      = ready;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'd0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_reqcyc", 64'(bus.reqcyc), 64'd0);
        checkOutput("rst_req", bus.req, 64'd0);
        checkOutput("rst_respack", 64'(bus.respack), 64'd0);
        checkOutput("rst_inst_valid", 64'(inst_valid), 64'd0);
        checkOutput("rst_halted", 64'(halted), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        req_log.delete();
        acked_log.delete();
        pop_pc.delete();
    endtask

    task automatic waitPops(input int n, input int limit);
        int c;
        c = 0;
        while (pop_pc.size() < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        checkOutput("pops_reached", 64'(pop_pc.size() >= n), 64'd1);
    endtask

    task automatic waitReqs(input int n, input int limit);
        int c;
        c = 0;
        while (req_log.size() < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        checkOutput("reqs_reached", 64'(req_log.size() >= n), 64'd1);
    endtask

    initial begin
        reset          = 1'b1;
        entry          = 64'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        inst_ready     = 1'b0;

        // Basic in-order fetch of one line, then the next line.
        $display("[TB] scenario 1: sequential fetch");
        applyStimulus(64'h1000, 1'b1);
        waitPops(16, 300);
        checkOutput("t1_req0", req_log[0], 64'h1000);
        for (int i = 0; i < 16; i++) begin
            checkOutput("t1_pc", pop_pc[i], 64'h1000 + 64'(4 * i));
        end
        waitReqs(2, 100);
        checkOutput("t1_req1", req_log[1], 64'h1040);

        // Back-pressure: two bursts fill the queue, a third needs 16 free slots.
        $display("[TB] scenario 2: back-pressure");
        applyStimulus(64'h1000, 1'b0);
        repeat (120) @(negedge clk);
        checkOutput("t2_reqs_full", 64'(req_log.size()), 64'd2);
        checkOutput("t2_req1", req_log[1], 64'h1040);
        inst_ready = 1'b1;
        repeat (15) @(negedge clk);
        inst_ready = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("t2_pops15", 64'(pop_pc.size()), 64'd15);
        checkOutput("t2_reqs_15", 64'(req_log.size()), 64'd2);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("t2_pops16", 64'(pop_pc.size()), 64'd16);
        checkOutput("t2_reqs_16", 64'(req_log.size()), 64'd3);
        checkOutput("t2_req2", req_log[2], 64'h1080);

        // Mid-line entry drops the leading words of the first line.
        $display("[TB] scenario 3: mid-line entry");
        applyStimulus(64'h1008, 1'b1);
        waitPops(15, 300);
        checkOutput("t3_req0", req_log[0], 64'h1000);
        checkOutput("t3_first", pop_pc[0], 64'h1008);
        checkOutput("t3_last_line", pop_pc[13], 64'h103C);
        checkOutput("t3_next_line", pop_pc[14], 64'h1040);

        // Redirect during beat 3 of a burst.
        $display("[TB] scenario 4: redirect during response");
        applyStimulus(64'h1000, 1'b0);
        redir_target = 64'h2000;
        redir_beat   = 3;
        waitReqs(2, 200);
        checkOutput("t4_acked", 64'(acked_log[0]), 64'd8);
        checkOutput("t4_req1", req_log[1], 64'h2000);
        repeat (20) @(negedge clk);
        #1;
        checkOutput("t4_valid", 64'(inst_valid), 64'd1);
        checkOutput("t4_head_pc", inst_pc, 64'h2000);
        checkOutput("t4_head_inst", 64'(inst), 64'(memWord(64'h2000)));
        checkOutput("t4_no_pops", 64'(pop_pc.size()), 64'd0);

        // Zero word halts fetch; a redirect resumes it.
        $display("[TB] scenario 5: zero word halt");
        applyStimulus(64'h1000, 1'b1);
        zero_en   = 1'b1;
        zero_addr = 64'h1014;
        repeat (80) @(negedge clk);
        #1;
        checkOutput("t5_pops", 64'(pop_pc.size()), 64'd5);
        checkOutput("t5_last_pc", pop_pc[4], 64'h1010);
        checkOutput("t5_reqs", 64'(req_log.size()), 64'd1);
        checkOutput("t5_acked", 64'(acked_log[0]), 64'd8);
        checkOutput("t5_halted", 64'(halted), 64'd1);
        @(negedge clk);
        redirect_pc    = 64'h1000;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checkOutput("t5_unhalt", 64'(halted), 64'd0);
        waitReqs(2, 50);
        checkOutput("t5_req1", req_log[1], 64'h1000);

        // Delayed ack with a redirect while the request is pending.
        $display("[TB] scenario 6: redirect during request");
        applyStimulus(64'h1000, 1'b1);
        ack_delay       = 5;
        redir_req_cycle = 1;
        redir_target    = 64'h3010;
        waitPops(1, 300);
        checkOutput("t6_req0", req_log[0], 64'h1000);
        checkOutput("t6_acked", 64'(acked_log[0]), 64'd8);
        checkOutput("t6_req1", req_log[1], 64'h3000);
        checkOutput("t6_first", pop_pc[0], 64'h3010);

        checkOutput("no_overflow", 64'(overflow_seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
